// File: rtl/grid_mem_arbiter.sv
// grid_mem_arbiter
//   Owns the single-port 12x20 Tetris grid memory (8-bit cell codes, 1-cycle
//   synchronous read). Video reads always win. Game logic gets the memory
//   through a req/gnt handshake. After reset, or on init_start, a sweeper
//   paints the border cells and clears the playfield.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   vid_req/vid_addr      video read strobe and cell address
//   vid_data/vid_valid    video read data, valid pulse two cycles after vid_req
//   gl_req/gl_we          game request (held until grant), 1 = write
//   gl_addr/gl_wdata      game cell address and write data
//   gl_gnt                1-cycle grant; the access executes in that cycle
//   gl_rdata/gl_rvalid    game read data, valid pulse two cycles after grant
//   gl_err                granted access had an address beyond the grid
//   gl_starve             sticky: a game request waited STARVE_LIMIT cycles
//   init_start/init_done  rerun the sweep / high while serving
//   mem_*                 memory address, write enable, write and read data
module grid_mem_arbiter #(
    parameter int         GRID_COLS    = 12,
    parameter int         GRID_ROWS    = 20,
    parameter logic [7:0] AIR_CODE     = 8'd0,
    parameter logic [7:0] BORDER_CODE  = 8'd8,
    parameter int         STARVE_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vid_req,
    input  logic [7:0] vid_addr,
    output logic [7:0] vid_data,
    output logic       vid_valid,
    input  logic       gl_req,
    input  logic       gl_we,
    input  logic [7:0] gl_addr,
    input  logic [7:0] gl_wdata,
    output logic       gl_gnt,
    output logic [7:0] gl_rdata,
    output logic       gl_rvalid,
    output logic       gl_err,
    output logic       gl_starve,
    input  logic       init_start,
    output logic       init_done,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    localparam int COLW = $clog2(GRID_COLS);
    localparam int ROWW = $clog2(GRID_ROWS);
    localparam int WCW  = $clog2(STARVE_LIMIT + 1);

    localparam logic [7:0]      LAST_ADDR = 8'(GRID_COLS * GRID_ROWS - 1);
    localparam logic [COLW-1:0] LAST_COL  = COLW'(GRID_COLS - 1);
    localparam logic [ROWW-1:0] LAST_ROW  = ROWW'(GRID_ROWS - 1);
    localparam logic [WCW-1:0]  WAIT_MAX  = WCW'(STARVE_LIMIT);
    localparam logic [WCW-1:0]  WAIT_TRIP = WCW'(STARVE_LIMIT - 1);

    typedef enum logic {
        ST_INIT,
        ST_SERVE
    } state_t;

    state_t state, state_nxt;

    logic [7:0]      sweep_addr;
    logic [COLW-1:0] col_cnt;
    logic [ROWW-1:0] row_cnt;
    logic [WCW-1:0]  wait_cnt;
    logic [7:0]      last_addr;

    logic vid_win, gl_win, sweep_wr;
    logic addr_bad, is_border;
    logic vid_p, gl_rd_p, gl_bad_p;

    assign addr_bad  = gl_addr > LAST_ADDR;
    assign is_border = (col_cnt == '0) || (col_cnt == LAST_COL) || (row_cnt == LAST_ROW);
    assign init_done = (state == ST_SERVE);

    // Arbitration and next state
    always_comb begin
        state_nxt = state;
        vid_win   = 1'b0;
        gl_win    = 1'b0;
        sweep_wr  = 1'b0;
        if (state == ST_INIT) begin
            if (vid_req) begin
                vid_win = 1'b1;
            end else begin
                sweep_wr = 1'b1;
                if (sweep_addr == LAST_ADDR) begin
                    state_nxt = ST_SERVE;
                end
            end
        end else begin
            if (init_start) begin
                state_nxt = ST_INIT;
            end
            if (vid_req) begin
                vid_win = 1'b1;
            end else if (gl_req) begin
                gl_win = 1'b1;
            end
        end
    end

    // Memory port and grant outputs. Forced quiet while reset is asserted,
    // since these follow the requests combinationally.
    always_comb begin
        mem_addr  = last_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        gl_gnt    = 1'b0;
        gl_err    = 1'b0;
        if (reset) begin
            if (vid_win) begin
                mem_addr = vid_addr;
            end else if (gl_win) begin
                mem_addr  = gl_addr;
                mem_we    = gl_we && !addr_bad;
                mem_wdata = gl_wdata;
                gl_gnt    = 1'b1;
                gl_err    = addr_bad;
            end else if (sweep_wr) begin
                mem_addr  = sweep_addr;
                mem_we    = 1'b1;
                mem_wdata = is_border ? BORDER_CODE : AIR_CODE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Sweep position; row/col track sweep_addr so no division is needed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sweep_addr <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
        end else if (sweep_wr) begin
            if (sweep_addr == LAST_ADDR) begin
                sweep_addr <= '0;
                col_cnt    <= '0;
                row_cnt    <= '0;
            end else begin
                sweep_addr <= sweep_addr + 8'd1;
                if (col_cnt == LAST_COL) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_addr <= '0;
        end else if (vid_win || gl_win || sweep_wr) begin
            last_addr <= mem_addr;
        end
    end

    // Starvation: flag sets on the edge that closes the STARVE_LIMIT-th denied cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            gl_starve <= 1'b0;
        end else begin
            if (!gl_req || gl_win) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (gl_req && !gl_win && (wait_cnt == WAIT_TRIP)) begin
                gl_starve <= 1'b1;
            end
        end
    end

    // Read return pipelines: mem_rdata is captured the cycle after the access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vid_p     <= 1'b0;
            vid_valid <= 1'b0;
            vid_data  <= '0;
            gl_rd_p   <= 1'b0;
            gl_bad_p  <= 1'b0;
            gl_rvalid <= 1'b0;
            gl_rdata  <= '0;
        end else begin
            vid_p     <= vid_win;
            vid_valid <= vid_p;
            if (vid_p) begin
                vid_data <= mem_rdata;
            end
            gl_rd_p   <= gl_win && !gl_we;
            gl_bad_p  <= gl_win && addr_bad;
            gl_rvalid <= gl_rd_p;
            if (gl_rd_p) begin
                gl_rdata <= gl_bad_p ? 8'h00 : mem_rdata;
            end
        end
    end

endmodule

// File: doc/grid_mem_arbiter.md
Name: grid_mem_arbiter

Overview:
- Owns the single-port Tetris grid memory (12x20 cells, 8-bit cell codes, 1-cycle synchronous read).
- Shares the memory between the video renderer (read-only, hard real-time, highest priority) and the game logic (read/write, req/gnt handshake).
- Contains an init sweeper that paints the border and clears the playfield after reset or on command.

Parameters:
- GRID_COLS, 12, cells per row; address = row*GRID_COLS + col.
- GRID_ROWS, 20, rows; last valid address = GRID_COLS*GRID_ROWS-1 (239).
- AIR_CODE, 8'd0, code written to playfield cells during init.
- BORDER_CODE, 8'd8, code written to border cells during init.
- STARVE_LIMIT, 16, consecutive denied game-request cycles before the starve flag sets.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- vid_req  in  1  video read strobe, 1 cycle.
- vid_addr  in  8  video cell address.
- vid_data  out  8  video read data.
- vid_valid  out  1  vid_data valid pulse.
- gl_req  in  1  game request; held until gl_gnt.
- gl_we  in  1  1 = write, 0 = read; sampled with gl_req.
- gl_addr  in  8  game cell address.
- gl_wdata  in  8  game write data.
- gl_gnt  out  1  1-cycle grant; the access executes in this cycle.
- gl_rdata  out  8  game read data.
- gl_rvalid  out  1  gl_rdata valid pulse.
- gl_err  out  1  1-cycle pulse: granted access had address > 239.
- gl_starve  out  1  sticky: game request waited STARVE_LIMIT cycles; cleared only by reset.
- init_start  in  1  pulse: rerun the init sweep.
- init_done  out  1  high when in SERVE state.
- mem_addr  out  8  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data, valid the cycle after address.

Behaviour:
- Reset (reset=0, async): state=INIT, sweep_addr=0, wait_cnt=0. All outputs 0: vid_data, vid_valid, gl_gnt, gl_rdata, gl_rvalid, gl_err, gl_starve, init_done, mem_*.
- States: INIT, SERVE.
- INIT:
  - Each cycle with vid_req=0, write sweep_addr: BORDER_CODE if col==0, col==GRID_COLS-1 or row==GRID_ROWS-1; otherwise AIR_CODE. Then sweep_addr++.
  - A cycle with vid_req=1 serves video and pauses the sweep.
  - After writing address 239: go to SERVE, sweep_addr=0.
  - gl_gnt is never asserted in INIT. init_start is ignored in INIT.
- SERVE priority per cycle, evaluated in this order:
  - init_start=1: go to INIT next cycle. This cycle is still arbitrated normally.
  - vid_req=1: the video access wins.
  - gl_req=1: the game access wins.
- Video access in cycle N: mem_addr=vid_addr, mem_we=0. mem_rdata is registered at the end of N+1, so vid_data is valid and vid_valid pulses in N+2 (latency 2). Back-to-back vid_req is legal and pipelines.
- Game access in cycle N:
  - gl_gnt=1 in N.
  - Write: mem_we=1, mem_addr=gl_addr, mem_wdata=gl_wdata.
  - Read: gl_rdata is valid and gl_rvalid pulses in N+2.
  - The requester may drop gl_req or present a new request from N+1.
- Address > 239 on a granted game access:
  - Write: mem_we is forced to 0.
  - Read: gl_rdata=8'h00 with the normal rvalid timing.
  - gl_err pulses in N in both cases.
- Starvation:
  - wait_cnt increments each cycle gl_req=1 without a grant (including cycles in INIT). It clears on grant or when gl_req=0.
  - When wait_cnt reaches STARVE_LIMIT, gl_starve sets. Video is never preempted.
- Idle cycles: mem_we=0 and mem_addr holds its previous value.
- Reset mid-sweep: abort and restart at address 0 after release. Pending read valid pulses are discarded.
- init_start during an in-flight game read: the read still completes with gl_rvalid.
- Widths: row/col are derived from sweep_addr by a col counter that wraps at GRID_COLS-1 and a row counter, not by division.

Test Plan:
- Release reset, no requests -> 240 consecutive writes; addr 0 = 8, addr 13 = 0, addr 11 = 8, addr 228 = 8. init_done rises on the cycle after the addr-239 write.
- During init, vid_req every other cycle -> sweep pauses on those cycles and init takes 480 cycles. vid_valid pulses 2 cycles after each vid_req.
- SERVE, gl_req write addr 25 data 8'h03, then read addr 25 -> gl_gnt each, gl_rvalid 2 cycles after the read grant, gl_rdata=8'h03.
- vid_req and gl_req in the same cycle -> video served; gl_gnt on the first cycle vid_req=0. Continuous vid_req for 16 cycles -> gl_starve=1 and stays set.
- gl write addr 240 -> gl_err pulse, mem_we stays 0. gl read addr 250 -> gl_rdata=8'h00, gl_rvalid pulses.
- Assert reset at sweep_addr=100, release -> sweep restarts at 0, all outputs 0 during reset. init_start in SERVE -> full resweep and init_done low for 240 cycles.
